// File: rtl/grad_3x3_multi.sv
// grad_3x3_multi: 3x3 Sobel/Scharr gradient-magnitude filter for the luma path.
// Output is sat((|Gx|+|Gy|) >> shift), optionally inverted, with border blanking at line start.
// Optional build macro GRAD_THRESH_EN adds i_threshold / o_edge (registered edge compare).
module grad_3x3_multi #(
  parameter int Y_DEPTH      = 8,
  parameter int SOBEL_SHIFT  = 0,
  parameter int SCHARR_SHIFT = 2,
  parameter int INVERT       = 0
) (
  input  logic               i_pclk,
  input  logic               i_arst,
  input  logic               i_valid,
  input  logic               i_sol,
  input  logic               i_mode,
  input  logic [Y_DEPTH-1:0] i_pixel_top,
  input  logic [Y_DEPTH-1:0] i_pixel_mid,
  input  logic [Y_DEPTH-1:0] i_pixel_bot,
`ifdef GRAD_THRESH_EN
  input  logic [Y_DEPTH-1:0] i_threshold,
  output logic               o_edge,
`endif
  output logic               o_valid,
  output logic [Y_DEPTH-1:0] o_pixel
);

  localparam int W = Y_DEPTH;

  // Column window (left / centre / right), each holding top, mid, bot
  logic [W-1:0] l_top, l_mid, l_bot;
  logic [W-1:0] c_top, c_mid, c_bot;
  logic [W-1:0] r_top, r_mid, r_bot;
  logic [1:0]   fill_cnt, fill_nxt;
  logic         fresh;
  logic         p0_valid, p0_int, p0_mode;

  // Window differences feeding the kernel
  logic [W:0]   d_tx, d_mx, d_bx, d_ry, d_cy, d_ly;
  logic [W+1:0] s1_xa, s1_ya;
  logic [W:0]   s1_xb, s1_yb;
  logic         s1_valid, s1_int, s1_mode;
  logic [W+4:0] s2_xa, s2_xb, s2_ya, s2_yb;
  logic         s2_valid, s2_int, s2_mode;
  logic [W+4:0] s3_gx, s3_gy;
  logic         s3_valid, s3_int, s3_mode;
  logic [W+3:0] s4_ax, s4_ay;
  logic         s4_valid, s4_int, s4_mode;
  logic [W+4:0] s5_sum, s5_mag;
  logic [W-1:0] s5_sat, s5_pix;

  // Outer weight a: 1 (Sobel) or 3 = 2+1 (Scharr), sign-extended to W+5
  function automatic logic [W+4:0] weight_a(input logic [W+1:0] x, input logic scharr);
    logic [W+4:0] e;
    e = {{3{x[W+1]}}, x};
    return scharr ? ((e << 1) + e) : e;
  endfunction

  // Centre weight b: 2 (Sobel) or 10 = 8+2 (Scharr), sign-extended to W+5
  function automatic logic [W+4:0] weight_b(input logic [W:0] x, input logic scharr);
    logic [W+4:0] e;
    e = {{4{x[W]}}, x};
    return scharr ? ((e << 3) + (e << 1)) : (e << 1);
  endfunction

  // Magnitude of a W+5 two's-complement gradient; fits W+4 bits
  function automatic logic [W+3:0] abs_g(input logic [W+4:0] g);
    logic [W+4:0] n;
    n = g[W+4] ? ('0 - g) : g;
    return n[W+3:0];
  endfunction

  // Next fill count: a line start, or the first beat after reset, restarts at column 0
  always_comb begin
    fill_nxt = fill_cnt;
    if (i_sol || fresh)
      fill_nxt = 2'd0;
    else if (fill_cnt != 2'd2)
      fill_nxt = fill_cnt + 2'd1;
  end

  // Window shift, fill counter and per-beat tags.
  // The cleared window is not real image data, so the first beat after reset is
  // treated as a line start: the first two beats after release stay border.
  always_ff @(posedge i_pclk) begin
    if (i_arst) begin
      {l_top, l_mid, l_bot} <= '0;
      {c_top, c_mid, c_bot} <= '0;
      {r_top, r_mid, r_bot} <= '0;
      fill_cnt <= '0;
      fresh    <= 1'b1;
      p0_valid <= 1'b0;
      p0_int   <= 1'b0;
      p0_mode  <= 1'b0;
    end else begin
      p0_valid <= i_valid;
      if (i_valid) begin
        {l_top, l_mid, l_bot} <= {c_top, c_mid, c_bot};
        {c_top, c_mid, c_bot} <= {r_top, r_mid, r_bot};
        {r_top, r_mid, r_bot} <= {i_pixel_top, i_pixel_mid, i_pixel_bot};
        fill_cnt <= fill_nxt;
        fresh    <= 1'b0;
        p0_int   <= (fill_nxt == 2'd2);
        p0_mode  <= i_mode;
      end
    end
  end

  // Pixel differences across the window (W+1 bit two's complement)
  always_comb begin
    d_tx = {1'b0, r_top} - {1'b0, l_top};
    d_mx = {1'b0, r_mid} - {1'b0, l_mid};
    d_bx = {1'b0, r_bot} - {1'b0, l_bot};
    d_ry = {1'b0, r_bot} - {1'b0, r_top};
    d_cy = {1'b0, c_bot} - {1'b0, c_top};
    d_ly = {1'b0, l_bot} - {1'b0, l_top};
  end

  // Datapath stages: differences, weighted partials, Gx/Gy, absolute values.
  // Outer-column differences are pre-summed since they share weight a.
  always_ff @(posedge i_pclk) begin
    if (i_arst) begin
      s1_xa <= '0; s1_xb <= '0; s1_ya <= '0; s1_yb <= '0;
      s2_xa <= '0; s2_xb <= '0; s2_ya <= '0; s2_yb <= '0;
      s3_gx <= '0; s3_gy <= '0;
      s4_ax <= '0; s4_ay <= '0;
      {s1_valid, s1_int, s1_mode} <= '0;
      {s2_valid, s2_int, s2_mode} <= '0;
      {s3_valid, s3_int, s3_mode} <= '0;
      {s4_valid, s4_int, s4_mode} <= '0;
    end else begin
      s1_xa <= {d_tx[W], d_tx} + {d_bx[W], d_bx};
      s1_xb <= d_mx;
      s1_ya <= {d_ry[W], d_ry} + {d_ly[W], d_ly};
      s1_yb <= d_cy;
      {s1_valid, s1_int, s1_mode} <= {p0_valid, p0_int, p0_mode};

      s2_xa <= weight_a(s1_xa, s1_mode);
      s2_xb <= weight_b(s1_xb, s1_mode);
      s2_ya <= weight_a(s1_ya, s1_mode);
      s2_yb <= weight_b(s1_yb, s1_mode);
      {s2_valid, s2_int, s2_mode} <= {s1_valid, s1_int, s1_mode};

      s3_gx <= s2_xa + s2_xb;
      s3_gy <= s2_ya + s2_yb;
      {s3_valid, s3_int, s3_mode} <= {s2_valid, s2_int, s2_mode};

      s4_ax <= abs_g(s3_gx);
      s4_ay <= abs_g(s3_gy);
      {s4_valid, s4_int, s4_mode} <= {s3_valid, s3_int, s3_mode};
    end
  end

  // Sum, mode-dependent shift, saturation, border blanking and inversion
  always_comb begin
    s5_sum = {1'b0, s4_ax} + {1'b0, s4_ay};
    s5_mag = s4_mode ? (s5_sum >> SCHARR_SHIFT) : (s5_sum >> SOBEL_SHIFT);
    s5_sat = (|s5_mag[W+4:W]) ? '1 : s5_mag[W-1:0];
    s5_pix = s4_int ? s5_sat : '0;
    if (INVERT != 0)
      s5_pix = ~s5_pix;
  end

  // Output register; o_pixel holds across bubbles
  always_ff @(posedge i_pclk) begin
    if (i_arst) begin
      o_valid <= 1'b0;
      o_pixel <= '0;
    end else begin
      o_valid <= s4_valid;
      if (s4_valid)
        o_pixel <= s5_pix;
    end
  end

`ifdef GRAD_THRESH_EN
  // Edge flag: saturated magnitude against threshold, interior beats only
  always_ff @(posedge i_pclk) begin
    if (i_arst)
      o_edge <= 1'b0;
    else if (s4_valid)
      o_edge <= s4_int && (s5_sat >= i_threshold);
  end
`endif

endmodule
